seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring shift-subtract divider; inverse datapath of the MULT2 multiplier.
//  Accepts dividend/divisor on a start pulse, iterates one quotient bit per clock, and
//  presents quotient/remainder with a one-cycle done strobe. Sits beside the multiplier.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request; sampled only when ready
//  dividend     in   WIDTH  numerator, captured on accepted start
//  divisor      in   WIDTH  denominator, captured on accepted start
//  ready        out  1      high in IDLE and DONE: start will be accepted
//  busy         out  1      high while iterating (RUN)
//  done         out  1      one-cycle strobe: results valid
//  quotient     out  WIDTH  result, held until next accepted start
//  remainder    out  WIDTH  result, held until next accepted start
//  div_by_zero  out  1      set with done when divisor==0; held like results
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset: state=IDLE, ready=1, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
//  - FSM IDLE -> RUN (start & divisor!=0) | DONE (start & divisor==0); RUN -> DONE after
//    WIDTH iterations; DONE -> RUN/DONE on start (back-to-back), else IDLE.
//  - Accept edge: latch operands, clear counter, clear partial remainder (WIDTH+1 bits).
//  - Each RUN edge: r = {r[W-1:0], q_msb}; trial = r - {0,divisor} (WIDTH+1-bit subtract);
//    if no borrow r=trial, shift 1 into q, else shift 0. Counter counts 0..WIDTH-1.
//  - Latency: done high in the cycle after the WIDTH-th RUN edge, i.e. WIDTH+1 edges after
//    the accept edge. done is exactly one cycle wide.
//  - Divide by zero: no RUN; done next edge; quotient=all ones, remainder=dividend,
//    div_by_zero=1.
//  - start while busy: ignored, no effect on in-flight operation or outputs.
//  - Outputs quotient/remainder/div_by_zero update only at the DONE transition; stable otherwise.
//  - rst_n asserted mid-RUN: operation aborted, all outputs to reset values immediately.
// CONFIGURATION
//  - SIGNED_DIV_EN defined: operands two's-complement; magnitudes divided, signs fixed up at
//    the DONE transition (no extra cycle). Quotient truncates toward zero; remainder takes
//    the dividend's sign. MIN/-1 wraps: quotient=MIN, remainder=0. Divide by zero: quotient=
//    all ones, remainder=dividend.
//  - Not defined: operands unsigned; no sign logic synthesized.
// STRUCTURE
//  - Shared package div_pkg: state enum (IDLE, RUN, DONE), counter-width constant
//    ($clog2(WIDTH+1)).
//  - Sub-module div_sub_stage: WIDTH+1-bit ripple subtractor (built from the team full adder,
//    inverted subtrahend, carry-in 1) returning difference and borrow; one instance.
//  - Top: FSM, counter, operand/remainder/quotient shift registers, sign fixup (macro-guarded).
// TESTING (WIDTH=8)
//  - 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 9 edges after accept.
//  - 255/1 -> 255, 0; 3/10 -> 0, 3; 200/200 -> 1, 0.
//  - 5/0 -> done 1 edge after accept; quotient=0xFF, remainder=5, div_by_zero=1.
//  - start pulsed every cycle during RUN -> ignored; next accept only in DONE (back-to-back).
//  - rst_n low at iteration 4 -> busy=0, done=0, outputs 0, ready=1; new op then correct.
//  - SIGNED_DIV_EN: -7/2 -> 0xFD, 0xFF; 7/-2 -> 0xFD, 0x01; -128/-1 -> 0x80, 0x00.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for the default operand width; other widths use cnt_bits()
    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

    // Bits needed to count 0..width
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Trial-subtraction stage: N-bit ripple subtractor a - b built from full-adder
// cells with the subtrahend inverted and carry-in tied to 1. borrow is high
// when b > a (no carry out of the top cell).
module div_sub_stage #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0]   carry;
    logic [N-1:0] b_inv;

    assign carry[0] = 1'b1;
    assign b_inv    = ~b;

    // One full-adder cell per bit
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i]    = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv[i]) | (a[i] & carry[i]) | (b_inv[i] & carry[i]);
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Optional macro SIGNED_DIV_EN: two's-complement operands, magnitudes divided
// and signs restored on the final iteration edge.
// Handshake: start is sampled only while ready is high (IDLE or DONE); an
// accepted start latches the operands. done is a one-cycle strobe; results
// stay valid and stable until the next accepted start.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           dbg_state
);

    localparam int             CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic             accept;
    logic             div_zero_in;
    logic             last_iter;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH:0]   r_sr;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             unused_r_msb;

    assign div_zero_in = (divisor == '0);
    assign last_iter   = (state == RUN) && (cnt == LAST);
    assign dbg_state   = state;

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;
    assign mag_a   = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign mag_b   = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    assign q_final = neg_q ? (~q_next + WIDTH'(1)) : q_next;
    assign r_final = neg_r ? (~r_next[WIDTH-1:0] + WIDTH'(1)) : r_next[WIDTH-1:0];
`else
    assign mag_a   = dividend;
    assign mag_b   = divisor;
    assign q_final = q_next;
    assign r_final = r_next[WIDTH-1:0];
`endif

    // Shift the next dividend bit into the partial remainder and try a subtract
    assign r_shift = {r_sr[WIDTH-1:0], q_sr[WIDTH-1]};

    div_sub_stage #(.N(WIDTH + 1)) u_sub (
        .a      (r_shift),
        .b      ({1'b0, dvs}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign r_next = borrow ? r_shift : trial;
    assign q_next = {q_sr[WIDTH-2:0], ~borrow};

    // Stored remainder never exceeds the divisor, so its top bit is not read back
    assign unused_r_msb = r_sr[WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = div_zero_in ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = div_zero_in ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Iteration datapath and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvs         <= '0;
            q_sr        <= '0;
            r_sr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            dvs  <= mag_b;
            q_sr <= mag_a;
            r_sr <= '0;
            if (div_zero_in) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt  <= cnt + CW'(1);
            q_sr <= q_next;
            r_sr <= r_next;
            if (last_iter) begin
                quotient    <= q_final;
                remainder   <= r_final;
                div_by_zero <= 1'b0;
            end
        end
    end

`ifdef SIGNED_DIV_EN
    // Result signs captured with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed cases, start spam
// during RUN, back-to-back accepts, mid-run reset, and random operands checked
// against an arithmetic reference model. Honours SIGNED_DIV_EN.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    state_t       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dz = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic definition
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
`ifdef SIGNED_DIV_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (sa == -(2 ** (W - 1)) && sb == -1) begin
            q = a; r = '0; dz = 1'b0;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
        end
`else
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
`endif
    endtask

    // Issue one operation and check latency, results and handshake outputs.
    // spam=1 keeps start high with random operands through RUN and leaves the
    // caller to supply the next operation in the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit spam);
        logic [W-1:0] eq, er;
        logic         edz;
        int           edges, exp_edges;
        model(a, b, eq, er, edz);
        exp_edges = (b == 0) ? 1 : W + 1;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        if (!spam) start = 1'b0;
        while (done !== 1'b1 && edges < 40) begin
            if (edges == 4) begin
                check("mid_busy", busy, 1);
                check("mid_ready", ready, 0);
                check("mid_q_held", quotient, last_q);
                check("mid_r_held", remainder, last_r);
                check("mid_dz_held", div_by_zero, last_dz);
            end
            if (spam) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(posedge clk); #1;
            edges++;
        end
        check("done_seen", done, 1);
        check("latency", edges, exp_edges);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edz);
        check("done_ready", ready, 1);
        check("done_busy", busy, 0);
        last_q  = eq;
        last_r  = er;
        last_dz = edz;
        if (!spam) begin
            @(posedge clk); #1;
            check("done_width", done, 0);
            check("q_hold", quotient, eq);
            check("r_hold", remainder, er);
        end
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        #23;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'd100, 8'd7, 1'b0);
        run_op(8'd255, 8'd1, 1'b0);
        run_op(8'd3, 8'd10, 1'b0);
        run_op(8'd200, 8'd200, 1'b0);
        run_op(8'd5, 8'd0, 1'b0);
        run_op(8'd0, 8'd9, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
`ifdef SIGNED_DIV_EN
        run_op(8'hF9, 8'd2, 1'b0);
        run_op(8'd7, 8'hFE, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0);
        run_op(8'h80, 8'd0, 1'b0);
`endif

        // Start held high through RUN, then back-to-back accepts in DONE
        run_op(8'd77, 8'd5, 1'b1);
        run_op(8'd143, 8'd12, 1'b1);
        run_op(8'd9, 8'd0, 1'b1);
        run_op(8'd250, 8'd3, 1'b0);

        // Reset asserted mid-run
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", ready, 1);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_dz", div_by_zero, 0);
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd100, 8'd7, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(a, b, ($urandom_range(0, 3) == 0));
        end
        run_op(8'd42, 8'd6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
